pmem_arbiter: RTL

//  Shares one physical-memory port between instruction-side and data-side requesters (I/D caches or the

---
 rtl/pmem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares one physical-memory port between an instruction-side
// requester and a data-side requester. One transaction is granted at a time
// and held until pmem_resp. Simultaneous requests alternate priority. A sticky
// err flag marks a granted transaction that has waited TIMEOUT cycles.
module pmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    // instruction side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,
    // data side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,
    // physical memory
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    // sticky timeout flag
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    // The wait counter is 16 bits; a 17-bit threshold keeps the comparison
    // well defined even for TIMEOUT values at the top of the counter range.
    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;   // 0 = I served last, 1 = D
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        i_req;
    logic        d_req;

    assign i_req = i_read;
    assign d_req = d_read | d_write;
    assign err   = err_q;

    // Next-state, wait counter, sticky error and all port outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        i_rdata      = '0;
        i_resp       = 1'b0;
        d_rdata      = '0;
        d_resp       = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (state_q)
            IDLE: begin
                // Stray pmem_resp is ignored here; only new requests matter.
                if (i_req && d_req) begin
                    state_d = last_grant_q ? GNT_I : GNT_D;
                end else if (i_req) begin
                    state_d = GNT_I;
                end else if (d_req) begin
                    state_d = GNT_D;
                end
                if (state_d != IDLE) begin
                    cnt_d = '0;
                end
            end
            GNT_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
                i_rdata      = pmem_rdata;
                i_resp       = pmem_resp;
                if (pmem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GNT_D: begin
                // Strobes follow the live inputs; a simultaneous read and
                // write is treated as a write with no read data returned.
                pmem_read    = d_read & ~d_write;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                d_rdata      = (d_read & d_write) ? '0 : pmem_rdata;
                d_resp       = pmem_resp;
                if (pmem_resp) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && !pmem_resp && ({1'b0, cnt_d} >= TIMEOUT_W)) begin
            err_d = 1'b1;
        end
    end

    // State, priority, counter and error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

endmodule
